// File: rtl/stream_axi_waddr_if.sv
// Burst write request bus between the write-side address sequencer and the AXI write master.
interface stream_axi_waddr_if;
    localparam int unsigned ADDR_W = 32;

    logic              kick;
    logic              busy;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] write_num;

    modport master (output kick, output write_addr, output write_num, input busy);
    modport slave  (input kick, input write_addr, input write_num, output busy);
endinterface

// File: rtl/stream_axi_waddr.sv
// Write-side address sequencer: turns received frames into FIFO-gated fixed-length burst
// write requests to the AXI write master, one frame of X_SIZE*Y_SIZE words from BASE_ADDR.
module stream_axi_waddr #(
    parameter int unsigned X_SIZE      = 256,
    parameter int unsigned Y_SIZE      = 256,
    parameter int unsigned BURST_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [31:0]               fifo_count,
    stream_axi_waddr_if.master        wr,
    output logic                      frame_done,
    output logic                      frame_abort
);

    localparam int unsigned FRAME_WORDS = X_SIZE * Y_SIZE;
    localparam logic [31:0] BURST_LEN   = 32'(BURST_WORDS);
    localparam logic [31:0] ADDR_STEP   = 32'(BURST_WORDS * 4);
    localparam logic [31:0] LAST_ADDR   = BASE_ADDR + 32'((FRAME_WORDS - BURST_WORDS) * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_ISSUE_IDLE,
        S_ISSUE,
        S_ISSUE_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        pend_q, pend_d;
    logic        kick_q;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        fifo_ok_c;
    logic        last_c;

    assign fifo_ok_c = (fifo_count >= BURST_LEN);
    assign last_c    = (addr_q == LAST_ADDR);

    // Next-state, address and pulse decode; a pending restart always wins over completion.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_WAIT_DATA;
                    addr_d  = BASE_ADDR;
                end
            end

            S_WAIT_DATA: begin
                if (frame_start) begin
                    addr_d  = BASE_ADDR;
                    abort_d = 1'b1;
                end else if (fifo_ok_c) begin
                    state_d = S_ISSUE_IDLE;
                end
            end

            S_ISSUE_IDLE: begin
                if (frame_start) begin
                    state_d = S_WAIT_DATA;
                    addr_d  = BASE_ADDR;
                    abort_d = 1'b1;
                end else if (!wr.busy) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = S_ISSUE_WAIT;
                if (frame_start) begin
                    pend_d = 1'b1;
                end
            end

            S_ISSUE_WAIT: begin
                if (wr.busy) begin
                    pend_d = 1'b0;
                    if (pend_q) begin
                        state_d = S_WAIT_DATA;
                        addr_d  = BASE_ADDR;
                        abort_d = 1'b1;
                    end else if (last_c) begin
                        done_d = 1'b1;
                        if (frame_start) begin
                            state_d = S_WAIT_DATA;
                            addr_d  = BASE_ADDR;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (frame_start) begin
                        state_d = S_WAIT_DATA;
                        addr_d  = BASE_ADDR;
                        abort_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_DATA;
                        addr_d  = addr_q + ADDR_STEP;
                    end
                end else if (frame_start) begin
                    pend_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; kick is decoded from the next state so it tracks the issue states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            pend_q  <= 1'b0;
            kick_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            kick_q  <= (state_d == S_ISSUE) || (state_d == S_ISSUE_WAIT);
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign wr.kick       = kick_q;
    assign wr.write_addr = addr_q;
    assign wr.write_num  = BURST_LEN;
    assign frame_done    = done_q;
    assign frame_abort   = abort_q;

endmodule

// File: tb/tb_stream_axi_waddr.sv
// Bench for stream_axi_waddr: directed scenarios plus randomized traffic against a
// request/accept-level reference model of the burst sequencer.
module tb_stream_axi_waddr;

    localparam int unsigned X_SIZE      = 16;
    localparam int unsigned Y_SIZE      = 16;
    localparam int unsigned BURST_WORDS = 64;
    localparam logic [31:0] BASE_ADDR   = 32'h1000_0000;
    localparam int unsigned N_BURSTS    = X_SIZE * Y_SIZE / BURST_WORDS;
    localparam logic [31:0] STEP        = 32'(BURST_WORDS * 4);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] fifo_count;
    logic        frame_done;
    logic        frame_abort;

    stream_axi_waddr_if wr ();

    stream_axi_waddr #(
        .X_SIZE      (X_SIZE),
        .Y_SIZE      (Y_SIZE),
        .BURST_WORDS (BURST_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .fifo_count  (fifo_count),
        .wr          (wr),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observed DUT events
    int          n_kick_rise = 0;
    int          n_done      = 0;
    int          n_abort     = 0;
    logic        prev_kick   = 1'b0;
    logic [31:0] rise_q[$];

    // Reference model: frame active, outstanding request, burst index, restart pending
    bit m_started = 0;
    bit m_active  = 0;
    bit m_req     = 0;
    bit m_pend    = 0;
    bit m_ready   = 0;
    int m_idx     = 0;
    int m_age     = 0;
    bit exp_done  = 0;
    bit exp_abort = 0;
    bit post_rst  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("kick", 32'(wr.kick), 32'(m_req));
                check("write_num", wr.write_num, 32'(BURST_WORDS));
                check("frame_done", 32'(frame_done), 32'(exp_done));
                check("frame_abort", 32'(frame_abort), 32'(exp_abort));
                if (m_req) check("write_addr", wr.write_addr, BASE_ADDR + 32'(m_idx) * STEP);
                if (post_rst) check("reset_addr", wr.write_addr, BASE_ADDR);
            end

            if (wr.kick === 1'b1 && prev_kick !== 1'b1) begin
                n_kick_rise++;
                rise_q.push_back(wr.write_addr);
            end
            prev_kick = wr.kick;
            if (frame_done === 1'b1) n_done++;
            if (frame_abort === 1'b1) n_abort++;

            if (!rst_n) begin
                m_active = 0; m_req = 0; m_pend = 0; m_ready = 0; m_idx = 0; m_age = 0;
                exp_done = 0; exp_abort = 0; post_rst = 1; m_started = 1;
            end else if (m_started) begin
                bit nreq, ndone, nabort;
                nreq = m_req; ndone = 0; nabort = 0; post_rst = 0;
                if (m_req) begin
                    // busy during the first request cycle is not an acceptance
                    if (m_age > 0 && wr.busy === 1'b1) begin
                        nreq = 0; m_ready = 0;
                        if (m_pend) begin
                            nabort = 1; m_idx = 0;
                        end else if (m_idx == int'(N_BURSTS) - 1) begin
                            ndone = 1; m_idx = 0;
                            if (!frame_start) m_active = 0;
                        end else if (frame_start) begin
                            nabort = 1; m_idx = 0;
                        end else begin
                            m_idx++;
                        end
                        m_pend = 0;
                    end else if (frame_start) begin
                        m_pend = 1;
                    end
                    m_age++;
                end else if (frame_start) begin
                    if (m_active) nabort = 1;
                    m_active = 1; m_idx = 0; m_ready = 0;
                end else if (m_active && m_ready && wr.busy === 1'b0) begin
                    nreq = 1; m_age = 0;
                end else if (m_active && fifo_count >= 32'(BURST_WORDS)) begin
                    m_ready = 1;
                end
                m_req = nreq; exp_done = ndone; exp_abort = nabort;
            end
        end
    end

    // AXI write master stand-in: 0 = respond to kick, 1 = busy stuck high, 2 = random
    int bmode    = 0;
    int resp_dly = 1;

    initial begin
        int hold, dly, hl, d;
        bit armed;
        hold = 0; dly = 0; hl = 3; armed = 0;
        wr.busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bmode == 1) begin
                wr.busy = 1'b1; hold = 0; armed = 0;
            end else begin
                wr.busy = (hold > 0);
                if (hold > 0) hold--;
                if (armed) begin
                    dly--;
                    if (dly == 0) begin armed = 0; hold = hl; end
                end else if (hold == 0 && !wr.busy && wr.kick === 1'b1) begin
                    d  = (bmode == 2) ? int'($urandom_range(1, 4)) : resp_dly;
                    hl = (bmode == 2) ? int'($urandom_range(1, 4)) : 3;
                    if (d <= 1) hold = hl;
                    else begin armed = 1; dly = d - 1; end
                end
                if (bmode == 2 && !armed && hold == 0 && !wr.busy && $urandom_range(0, 15) == 0)
                    hold = int'($urandom_range(1, 3));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = n_done;
        int t  = 0;
        while (n_done == d0 && t < budget) begin tick(1); t++; end
        check(tag, 32'(n_done - d0), 32'd1);
    endtask

    task automatic wait_kick(input string tag, input int budget);
        int k0 = n_kick_rise;
        int t  = 0;
        while (n_kick_rise == k0 && t < budget) begin tick(1); t++; end
        check(tag, 32'(n_kick_rise - k0), 32'd1);
    endtask

    initial begin
        int k0, d0, a0, t;
        rst_n = 1'b0; frame_start = 1'b0; fifo_count = 32'd0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("t1_kick", 32'(wr.kick), 32'd0);
        check("t1_addr", wr.write_addr, 32'h1000_0000);
        check("t1_done", 32'(frame_done), 32'd0);
        check("t1_num", wr.write_num, 32'd64);
        rst_n = 1'b1;
        tick(2);

        // Full frame with FIFO at exactly one burst
        fifo_count = 32'd64; bmode = 0; resp_dly = 1;
        rise_q.delete(); k0 = n_kick_rise; d0 = n_done;
        pulse_start();
        wait_done("t2_done", 300);
        check("t2_kicks", 32'(n_kick_rise - k0), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t2_burst_addr", rise_q[i], 32'h1000_0000 + 32'(i) * 32'h100);
        tick(3);

        // Starved FIFO
        fifo_count = 32'd63; k0 = n_kick_rise;
        pulse_start();
        tick(50);
        check("t3_starved_kicks", 32'(n_kick_rise - k0), 32'd0);
        check("t3_starved_kick", 32'(wr.kick), 32'd0);
        fifo_count = 32'd64;
        wait_kick("t3_kick_after_fill", 20);
        wait_done("t3_done", 300);
        tick(3);

        // Busy stuck high blocks issue
        bmode = 1; k0 = n_kick_rise;
        pulse_start();
        tick(20);
        check("t4_busy_kicks", 32'(n_kick_rise - k0), 32'd0);
        bmode = 0;
        wait_kick("t4_kick_after_busy", 20);
        wait_done("t4_done", 300);
        tick(5);

        // Early frame_start while burst 2 waits for acceptance
        resp_dly = 3; rise_q.delete();
        k0 = n_kick_rise; d0 = n_done; a0 = n_abort;
        pulse_start();
        t = 0;
        while (n_kick_rise < k0 + 2 && t < 200) begin tick(1); t++; end
        check("t5_second_kick", 32'(n_kick_rise - k0), 32'd2);
        pulse_start();
        t = 0;
        while (n_kick_rise < k0 + 3 && t < 200) begin tick(1); t++; end
        check("t5_burst2_addr", rise_q[1], 32'h1000_0100);
        check("t5_restart_addr", rise_q[2], 32'h1000_0000);
        check("t5_abort", 32'(n_abort - a0), 32'd1);
        check("t5_no_done", 32'(n_done - d0), 32'd0);
        wait_done("t5_done", 400);
        resp_dly = 1;
        tick(5);

        // Reset while a request is outstanding
        d0 = n_done; a0 = n_abort;
        pulse_start();
        t = 0;
        while (wr.kick !== 1'b1 && t < 50) begin tick(1); t++; end
        check("t6_kick_seen", 32'(wr.kick), 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_kick", 32'(wr.kick), 32'd0);
        check("t6_addr", wr.write_addr, 32'h1000_0000);
        tick(10);
        check("t6_no_done", 32'(n_done - d0), 32'd0);
        check("t6_no_abort", 32'(n_abort - a0), 32'd0);

        // Randomized traffic
        bmode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fifo_count = 32'($urandom_range(40, 90));
            frame_start = ($urandom_range(0, 29) == 0);
            rst_n       = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        rst_n = 1'b1; frame_start = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
